// File: rtl/rr_arb_4x_nbit.sv
// rr_arb_4x_nbit: round-robin arbiter sharing one BUS_WIDTH-bit channel among
// four valid/ready requesters. A grant to a beat without 'last' locks the
// channel to that requester until its last beat. The winning beat goes into a
// one-entry output register along with its source index.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid[3:0]   per-requester beat valid
//   in_last[3:0]    per-requester end-of-burst flag
//   in_data_a..d    requester 0..3 data
//   in_ready[3:0]   per-requester accept (one-hot or zero, combinational)
//   out_valid       output register holds a beat
//   out_ready       downstream accepts
//   out_data        registered selected data
//   out_src         index of the requester that supplied out_data
//   out_last        registered last flag of the accepted beat
module rr_arb_4x_nbit #(
   parameter int unsigned BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           in_valid,
   input  logic [3:0]           in_last,
   input  logic [BUS_WIDTH-1:0] in_data_a,
   input  logic [BUS_WIDTH-1:0] in_data_b,
   input  logic [BUS_WIDTH-1:0] in_data_c,
   input  logic [BUS_WIDTH-1:0] in_data_d,
   output logic [3:0]           in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] out_data,
   output logic [1:0]           out_src,
   output logic                 out_last
);

   localparam int unsigned NUM_REQ = 4;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             ptr_q, ptr_d;
   logic [1:0]             owner_q, owner_d;
   logic                   out_valid_q, out_valid_d;
   logic [BUS_WIDTH-1:0]   out_data_q, out_data_d;
   logic [1:0]             out_src_q, out_src_d;
   logic                   out_last_q, out_last_d;

   logic [1:0]             win;
   logic                   win_found;
   logic [1:0]             cand;
   logic                   load_en;
   logic [1:0]             sel;
   logic [3:0]             grant;
   logic                   xfer;
   logic [BUS_WIDTH-1:0]   sel_data;

   // First valid requester searching ptr, ptr+1, ... (mod 4).
   always_comb begin
      win       = ptr_q;
      win_found = 1'b0;
      cand      = ptr_q;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         cand = 2'(ptr_q + 2'(k));
         if (!win_found && in_valid[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

   // Grant generation, data select and next-state logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_last_d  = out_last_q;
      grant       = 4'b0000;

      // The output register can take a beat when empty or draining this cycle.
      load_en = ~out_valid_q | out_ready;
      sel     = (state_q == ST_BURST) ? owner_q : win;

      if (!rst) begin
         if (state_q == ST_BURST) begin
            // Owner keeps the channel even if its valid drops mid-burst.
            grant[owner_q] = load_en;
         end else if (load_en && win_found) begin
            grant[win] = 1'b1;
         end
      end

      xfer = |(grant & in_valid);

      case (sel)
         2'd0:    sel_data = in_data_a;
         2'd1:    sel_data = in_data_b;
         2'd2:    sel_data = in_data_c;
         default: sel_data = in_data_d;
      endcase

      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_src_d   = sel;
         out_last_d  = in_last[sel];
         if (state_q == ST_ARB) begin
            ptr_d = 2'(sel + 2'd1);
            if (!in_last[sel]) begin
               state_d = ST_BURST;
               owner_d = sel;
            end
         end else if (in_last[sel]) begin
            state_d = ST_ARB;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   assign in_ready = grant;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ARB;
         ptr_q       <= 2'd0;
         owner_q     <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 2'd0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_arb_4x_nbit.sv
// Bench for rr_arb_4x_nbit: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural arbiter model.
module tb_rr_arb_4x_nbit;

   localparam int unsigned BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    in_valid;
   logic [3:0]    in_last;
   logic [BW-1:0] d [4];
   logic [3:0]    in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic [1:0]    out_src;
   logic          out_last;

   always #5 clk = ~clk;

   rr_arb_4x_nbit #(.BUS_WIDTH(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data_a (d[0]),
      .in_data_b (d[1]),
      .in_data_c (d[2]),
      .in_data_d (d[3]),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: pointer, burst ownership and the output register.
   int            m_ptr   = 0;
   bit            m_burst = 1'b0;
   int            m_owner = 0;
   bit            m_ov    = 1'b0;
   logic [BW-1:0] m_od    = '0;
   int            m_os    = 0;
   bit            m_ol    = 1'b0;

   logic [3:0]    obs_rdy;
   logic [3:0]    exp_rdy;
   logic [3:0]    last_xfer = 4'b0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Which requester the rules allow to transfer this cycle.
   function automatic logic [3:0] model_ready();
      bit load;
      if (rst) return 4'b0000;
      load = !m_ov || out_ready;
      if (!load) return 4'b0000;
      if (m_burst) return 4'(1 << m_owner);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (in_valid[i]) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   // One clock: check grant before the edge, advance the model, check outputs after.
   task automatic cyc();
      int w;
      #1;
      exp_rdy = model_ready();
      obs_rdy = in_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      last_xfer = exp_rdy & in_valid;
      if (rst) begin
         m_ptr = 0; m_burst = 1'b0; m_owner = 0;
         m_ov = 1'b0; m_od = '0; m_os = 0; m_ol = 1'b0;
      end else if (last_xfer != 4'b0000) begin
         w = 0;
         for (int i = 0; i < 4; i++) if (last_xfer[i]) w = i;
         m_ov = 1'b1;
         m_od = d[w];
         m_os = w;
         m_ol = in_last[w];
         if (!m_burst) begin
            m_ptr = (w + 1) % 4;
            if (!in_last[w]) begin
               m_burst = 1'b1;
               m_owner = w;
            end
         end else if (in_last[w]) begin
            m_burst = 1'b0;
         end
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data",  32'(out_data),  32'(m_od));
      chk("out_src",   32'(out_src),   32'(m_os));
      chk("out_last",  32'(out_last),  32'(m_ol));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      d[0]      = 8'h11;
      d[1]      = 8'h22;
      d[2]      = 8'h33;
      d[3]      = 8'h44;
      out_ready = 1'b1;

      // Reset with all requesters valid.
      repeat (2) begin
         cyc();
         chk("rst_ready", 32'(obs_rdy), 32'h0);
         chk("rst_ovalid", 32'(out_valid), 32'h0);
         chk("rst_odata", 32'(out_data), 32'h0);
      end
      rst = 1'b0;

      // Round-robin across four single-beat requesters.
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr_grant", 32'(obs_rdy), 32'(1 << (i % 4)));
         chk("rr_src", 32'(out_src), 32'(i % 4));
         chk("rr_data", 32'(out_data), 32'(8'h11 * (i % 4 + 1)));
      end

      // Pointer skip: bring ptr to 2, then only 0 and 1 request.
      in_valid = 4'b0011;
      cyc();
      cyc();
      cyc();
      chk("skip_g0", 32'(obs_rdy), 32'h1);
      cyc();
      chk("skip_g1", 32'(obs_rdy), 32'h2);

      // Burst lock: ptr to 1, then requester 1 sends 3 beats against 0 and 2.
      in_valid = 4'b0001;
      cyc();
      in_valid = 4'b0111;
      in_last  = 4'b1101;
      cyc();
      chk("burst_b1", 32'(obs_rdy), 32'h2);
      cyc();
      chk("burst_b2", 32'(obs_rdy), 32'h2);
      chk("burst_src2", 32'(out_src), 32'h1);
      in_last = 4'b1111;
      cyc();
      chk("burst_b3", 32'(obs_rdy), 32'h2);
      chk("burst_src3", 32'(out_src), 32'h1);
      chk("burst_last3", 32'(out_last), 32'h1);
      cyc();
      chk("burst_next", 32'(obs_rdy), 32'h4);

      // Backpressure with requester 2's beat held in the output register.
      out_ready = 1'b0;
      in_valid  = 4'b0001;
      repeat (4) begin
         cyc();
         chk("bp_ready", 32'(obs_rdy), 32'h0);
         chk("bp_data", 32'(out_data), 32'h33);
         chk("bp_valid", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_release", 32'(obs_rdy), 32'h1);
      chk("bp_ovalid", 32'(out_valid), 32'h1);
      chk("bp_src", 32'(out_src), 32'h0);

      // Reset after beat 2 of a burst from requester 3.
      in_valid = 4'b1000;
      in_last  = 4'b0000;
      cyc();
      cyc();
      rst      = 1'b1;
      in_valid = 4'b1001;
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_mid_grant", 32'(obs_rdy), 32'h1);
      in_last = 4'b1111;

      // Randomized traffic; a pending beat stays stable until it transfers.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!(in_valid[i] && !last_xfer[i])) begin
               in_valid[i] = ($urandom_range(0, 2) != 0);
               d[i]        = 8'($urandom);
               in_last[i]  = ($urandom_range(0, 2) != 0);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb_4x_nbit.md
# rr_arb_4x_nbit

Round-robin arbiter that shares a single BUS_WIDTH-bit output channel among four valid/ready requesters. It performs the 4:1 data selection internally, registers the winning beat into a one-entry output stage, and reports the source index. Grants can be held across multi-beat bursts delimited by `last`. It sits in front of any shared downstream consumer that previously used a static 4:1 select.

## Interface
- BUS_WIDTH, 8, width of each data bus

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  4  per-requester beat valid, bit i = requester i
- in_last  in  4  per-requester end-of-burst flag, qualified by in_valid[i]
- in_data_a  in  BUS_WIDTH  requester 0 data
- in_data_b  in  BUS_WIDTH  requester 1 data
- in_data_c  in  BUS_WIDTH  requester 2 data
- in_data_d  in  BUS_WIDTH  requester 3 data
- in_ready  out  4  per-requester accept, at most one bit set (one-hot or zero)
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts
- out_data  out  BUS_WIDTH  registered selected data
- out_src  out  2  index of requester that supplied out_data
- out_last  out  1  registered copy of the accepted beat's last flag

## Operation
- Transfer on input i: in_valid[i] & in_ready[i] at a rising edge. Transfer on output: out_valid & out_ready.
- load_en = ~out_valid | out_ready. Input transfers happen only when load_en is 1; the output stage therefore never drops or overwrites a beat.
- in_ready is combinational from state, ptr, in_valid, out_valid and out_ready. It is forced to 4'b0000 while rst = 1.
- State ARB, meaning no owner:
  - If load_en is 1 and any in_valid bit is set, the winner is the first set bit found searching ptr, ptr+1, ..., ptr+3 (mod 4). in_ready[winner] = 1.
  - On that transfer, ptr <= winner+1 mod 4.
  - If in_last[winner] = 0, the block goes to BURST with owner = winner. Otherwise it stays in ARB.
  - If no in_valid bit is set, or load_en = 0, in_ready = 0 and ptr is unchanged.
- State BURST, owner fixed:
  - in_ready[owner] = load_en. All other bits are 0, regardless of their valid.
  - On an owner transfer with in_last = 1, the block returns to ARB. ptr is not changed in BURST.
  - An owner that deasserts valid mid-burst keeps the channel. There is no timeout.
- Output stage:
  - On an input transfer, out_data <= selected data, out_src <= winner/owner, out_last <= in_last[sel], out_valid <= 1.
  - If the output transfers with no new input transfer, out_valid <= 0. out_data, out_src and out_last hold their values.
  - When an output transfer and an input transfer occur in the same cycle, the register loads the new beat and out_valid stays 1.
- Data width rule: data passes through unmodified, with no truncation or extension.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_src = 0, out_last = 0, in_ready = 0, ptr = 0, state = ARB.
- Reset applied mid-burst abandons the burst. The next cycle after rst deasserts is ARB with ptr = 0.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N, which is 1 cycle.
- Throughput: 1 beat per cycle when out_ready is held at 1.
- Backpressure: when out_valid = 1 and out_ready = 0, all in_ready bits are 0 in the same cycle.
- Simultaneous requests: exactly one grant per cycle. Across ARB decisions, each requester waits at most 3 other grants; bursts extend this wait by their length.
- in_valid must stay asserted with stable data and last until its transfer. The arbiter does not require this for correctness of its own state.

## Test plan
- Reset and idle: hold rst for 2 cycles with all in_valid = 4'b1111. Required: in_ready = 0, out_valid = 0, out_data = 0 throughout. After release, the first grant goes to requester 0.
- Round-robin: all four requesters valid with last = 1, data a = 8'h11, b = 8'h22, c = 8'h33, d = 8'h44, out_ready = 1. Required: out_src sequence 0,1,2,3,0,... on consecutive cycles, out_data 11,22,33,44,11,..., first out_valid one cycle after the first grant.
- Pointer skip: ptr = 2, only requesters 0 and 1 valid. Required: grant to 0, then ptr = 1, next grant to 1.
- Burst lock: requester 1 sends 3 beats (last on the third) while requesters 0 and 2 are valid. Required: out_src = 1 for 3 consecutive beats, then grant to 2.
- Backpressure: out_ready = 0 for 4 cycles with a beat held. Required: out_data stable, in_ready = 0. With out_ready = 1 and a pending request in the same cycle, the old beat and the new beat transfer together and out_valid stays 1.
- Reset mid-burst: assert rst after beat 2 of a 4-beat burst from requester 3. Required: ARB state and ptr = 0 after reset; requester 0 wins if it is valid.
